// File: rtl/surf_dac_loader.sv
// -----------------------------------------------------------------------------
// surf_dac_loader
//
// Holds the 32 x 16-bit threshold/bias DAC setpoints written over the local
// bus and streams all of them to four 8-channel serial DACs whenever a load
// is requested.
//
// Ports:
//   clk_i         system clock (33 MHz local-bus clock)
//   rst_i         asynchronous active-high reset (control path only)
//   dac_wr_i      write strobe, one setpoint per cycle while high
//   dac_waddr_i   write address (physical channel: chip = [4:3], ch = [2:0])
//   dac_dat_i     write data
//   dac_raddr_i   readback address
//   dac_dat_o     readback data, combinational from dac_raddr_i
//   dac_update_i  single-cycle request for a full 32-channel load
//   dac_busy_o    high while a load pass is running or pending
//   dac_sclk_o    serial clock, idles low
//   dac_din_o     serial data, MSB first
//   dac_nsync_o   per-chip frame select, active-low
// -----------------------------------------------------------------------------
module surf_dac_loader #(
    parameter int unsigned SCLK_HALF   = 2,
    parameter int unsigned SYNC_GAP    = 2,
    parameter logic [3:0]  CMD         = 4'h3,
    parameter logic [15:0] DEFAULT_VAL = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dac_wr_i,
    input  logic [4:0]  dac_waddr_i,
    input  logic [15:0] dac_dat_i,
    input  logic [4:0]  dac_raddr_i,
    output logic [15:0] dac_dat_o,
    input  logic        dac_update_i,
    output logic        dac_busy_o,
    output logic        dac_sclk_o,
    output logic        dac_din_o,
    output logic [3:0]  dac_nsync_o
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

    localparam int unsigned TMAX = (SCLK_HALF > SYNC_GAP) ? SCLK_HALF : SYNC_GAP;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] HALF_END = TW'(SCLK_HALF - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(SYNC_GAP - 1);

    // Setpoint RAM: contents survive reset, only configuration sets them.
    logic [15:0] mem [32] = '{default: DEFAULT_VAL};

    always_ff @(posedge clk_i) begin
        if (dac_wr_i)
            mem[dac_waddr_i] <= dac_dat_i;
    end

    assign dac_dat_o = mem[dac_raddr_i];

    state_t        state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [4:0]    bit_cnt, bit_n;
    logic [4:0]    ch_cnt, ch_n;
    logic          pending, pend_n;
    logic [23:0]   sr, sr_n;
    logic          busy_n, sclk_n, din_n;
    logic [3:0]    nsync_n;

    always_comb begin
        state_n = state;
        tmr_n   = tmr + TW'(1);
        bit_n   = bit_cnt;
        ch_n    = ch_cnt;
        sr_n    = sr;
        // Requests during a pass collapse into a single sticky flag.
        pend_n  = pending | (dac_update_i && (state != IDLE));

        case (state)
            IDLE: begin
                tmr_n = '0;
                if (dac_update_i || pending) begin
                    state_n = LOAD;
                    ch_n    = 5'd0;
                    pend_n  = 1'b0;
                end
            end
            LOAD: begin
                // RAM read sees the pre-write value if a write hits this edge.
                sr_n    = {CMD, 1'b0, ch_cnt[2:0], mem[ch_cnt]};
                bit_n   = 5'd0;
                tmr_n   = '0;
                state_n = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (tmr == HALF_END) begin
                    tmr_n   = '0;
                    state_n = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tmr == HALF_END) begin
                    tmr_n = '0;
                    sr_n  = {sr[22:0], 1'b0};
                    if (bit_cnt == 5'd23) begin
                        state_n = HOLD;
                    end else begin
                        bit_n   = bit_cnt + 5'd1;
                        state_n = SHIFT_LO;
                    end
                end
            end
            HOLD: begin
                if (tmr == HALF_END) begin
                    tmr_n   = '0;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (tmr == GAP_END) begin
                    tmr_n = '0;
                    if (ch_cnt != 5'd31) begin
                        ch_n    = ch_cnt + 5'd1;
                        state_n = LOAD;
                    end else if (pending) begin
                        pend_n  = 1'b0;
                        ch_n    = 5'd0;
                        state_n = LOAD;
                    end else begin
                        // A same-cycle request stays in pend_n and restarts from IDLE.
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tmr_n   = '0;
            end
        endcase

        // Outputs are derived from the next state so the registers line up
        // with the state they describe.
        busy_n  = (state_n != IDLE) || pend_n;
        sclk_n  = (state_n == SHIFT_HI);
        din_n   = ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) ? sr_n[23] : 1'b0;
        nsync_n = 4'hF;
        if ((state_n == SHIFT_LO) || (state_n == SHIFT_HI) || (state_n == HOLD))
            nsync_n[ch_n[4:3]] = 1'b0;
    end

    // Control and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            tmr         <= '0;
            bit_cnt     <= 5'd0;
            ch_cnt      <= 5'd0;
            pending     <= 1'b0;
            dac_busy_o  <= 1'b0;
            dac_sclk_o  <= 1'b0;
            dac_din_o   <= 1'b0;
            dac_nsync_o <= 4'hF;
        end else begin
            state       <= state_n;
            tmr         <= tmr_n;
            bit_cnt     <= bit_n;
            ch_cnt      <= ch_n;
            pending     <= pend_n;
            dac_busy_o  <= busy_n;
            dac_sclk_o  <= sclk_n;
            dac_din_o   <= din_n;
            dac_nsync_o <= nsync_n;
        end
    end

    // Frame shift register (datapath, reloaded before every use)
    always_ff @(posedge clk_i) begin
        sr <= sr_n;
    end

endmodule

// File: tb/tb_surf_dac_loader.sv
module tb_surf_dac_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic [4:0]  waddr = '0;
    logic [15:0] wdat = '0;
    logic [4:0]  raddr = '0;
    logic [15:0] rdat;
    logic        upd = 1'b0;
    logic        busy, sclk, din;
    logic [3:0]  nsync;

    always #5 clk = ~clk;

    surf_dac_loader dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .dac_wr_i     (wr),
        .dac_waddr_i  (waddr),
        .dac_dat_i    (wdat),
        .dac_raddr_i  (raddr),
        .dac_dat_o    (rdat),
        .dac_update_i (upd),
        .dac_busy_o   (busy),
        .dac_sclk_o   (sclk),
        .dac_din_o    (din),
        .dac_nsync_o  (nsync)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: setpoint contents and the frames a DAC would receive.
    logic [15:0] ram [32];
    logic [15:0] snap [32];
    logic [23:0] exp_data [$];
    logic [23:0] fr_data [$];
    int          fr_chip [$];
    int          fr_nb [$];
    int          bad_sync = 0;
    int          din_glitch = 0;
    int          stray = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // DAC-side monitor: shifts din on sclk rising edges while a chip is selected.
    initial begin
        logic        prev_sclk = 1'b0;
        logic        prev_din = 1'b0;
        logic        in_frame = 1'b0;
        logic [3:0]  pat = 4'hF;
        logic [23:0] cur = '0;
        int          nb = 0;
        int          chip;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame  = 1'b0;
                prev_sclk = 1'b0;
                prev_din  = 1'b0;
            end else begin
                if (!in_frame && nsync != 4'hF) begin
                    in_frame = 1'b1;
                    cur = '0;
                    nb  = 0;
                    pat = nsync;
                end
                if (in_frame && nsync != 4'hF && nsync != pat) bad_sync++;
                if (sclk && !prev_sclk) begin
                    if (in_frame) begin
                        cur = {cur[22:0], din};
                        nb++;
                    end else begin
                        stray++;
                    end
                end
                if (sclk && prev_sclk && din != prev_din) din_glitch++;
                if (in_frame && nsync == 4'hF) begin
                    case (pat)
                        4'hE: chip = 0;
                        4'hD: chip = 1;
                        4'hB: chip = 2;
                        4'h7: chip = 3;
                        default: chip = 7;
                    endcase
                    fr_data.push_back(cur);
                    fr_chip.push_back(chip);
                    fr_nb.push_back(nb);
                    in_frame = 1'b0;
                end
                prev_sclk = sclk;
                prev_din  = din;
            end
        end
    end

    task automatic write_word(input logic [4:0] a, input logic [15:0] d);
        wr = 1'b1; waddr = a; wdat = d;
        @(negedge clk);
        wr = 1'b0;
        ram[a] = d;
    endtask

    task automatic readback_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            raddr = 5'(i);
            #1;
            check($sformatf("%s_%0d", tag, i), 48'(rdat), 48'(ram[i]));
        end
    endtask

    task automatic take_snapshot();
        for (int i = 0; i < 32; i++) snap[i] = ram[i];
    endtask

    task automatic add_pass();
        for (int c = 0; c < 32; c++) begin
            logic [4:0] a;
            a = 5'(c);
            exp_data.push_back({4'h3, 1'b0, a[2:0], snap[c]});
        end
    endtask

    task automatic clear_frames();
        fr_data.delete(); fr_chip.delete(); fr_nb.delete(); exp_data.delete();
    endtask

    task automatic check_frames(input string tag);
        int n;
        check({tag, "_nframes"}, 48'(fr_data.size()), 48'(exp_data.size()));
        n = (fr_data.size() < exp_data.size()) ? fr_data.size() : exp_data.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_frame%0d", tag, i),
                  {8'(fr_chip[i]), 8'(fr_nb[i]), 8'h0, fr_data[i]},
                  {8'((i % 32) / 8), 8'd24, 8'h0, exp_data[i]});
    endtask

    // Pulses update, then runs until busy falls. Optional extra update strobes
    // and the two-word write burst are injected at the given cycle numbers.
    task automatic run_pass(input string tag, input int upd1, input int upd2,
                            input int wr_at, output int blen);
        bit done = 1'b0;
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        blen = 0;
        for (int k = 1; k < 20000 && !done; k++) begin
            if (k == 1) check({tag, "_busy_rise"}, 48'(busy), 48'd1);
            if (busy) blen++;
            else done = 1'b1;
            upd = !done && (k == upd1 || k == upd2);
            if (!done && k == wr_at) begin
                wr = 1'b1; waddr = 5'd7; wdat = 16'hFFFF;
            end else if (!done && k == wr_at + 1) begin
                wr = 1'b1; waddr = 5'd20; wdat = 16'h0001;
            end else begin
                wr = 1'b0;
            end
            if (!done) @(negedge clk);
        end
        upd = 1'b0;
        wr = 1'b0;
        check({tag, "_busy_fell"}, 48'(done), 48'd1);
        check({tag, "_idle_nsync"}, 48'(nsync), 48'hF);
    endtask

    initial begin
        int blen;
        for (int i = 0; i < 32; i++) ram[i] = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_nsync", 48'(nsync), 48'hF);
        check("rst_sclk", 48'(sclk), 48'd0);
        check("rst_din", 48'(din), 48'd0);
        readback_all("rst_read");

        // Write/readback: old value in the write cycle, new value after
        raddr = 5'd5; wr = 1'b1; waddr = 5'd5; wdat = 16'h1234;
        #1 check("wr5_same", 48'(rdat), 48'(ram[5]));
        @(negedge clk);
        wr = 1'b0; ram[5] = 16'h1234;
        #1 check("wr5_next", 48'(rdat), 48'h1234);
        @(negedge clk);
        raddr = 5'd26; wr = 1'b1; waddr = 5'd26; wdat = 16'hBEEF;
        #1 check("wr26_same", 48'(rdat), 48'(ram[26]));
        @(negedge clk);
        wr = 1'b0; ram[26] = 16'hBEEF;
        #1 check("wr26_next", 48'(rdat), 48'hBEEF);
        @(negedge clk);

        // Random fill, then the directed value for channel 11
        for (int i = 0; i < 32; i++) write_word(5'(i), 16'($urandom));
        write_word(5'd11, 16'hA5C3);
        readback_all("fill_read");

        // Single pass
        clear_frames(); take_snapshot(); add_pass();
        run_pass("single", -1, -1, -1, blen);
        check("single_busy_len", 48'(blen), 48'd3232);
        check_frames("single");
        if (fr_data.size() > 11) begin
            check("frame11_word", 48'(fr_data[11]), 48'h33A5C3);
            check("frame11_chip", 48'(fr_chip[11]), 48'd1);
        end

        // Two strobes during a pass collapse to one extra pass
        for (int i = 0; i < 8; i++) write_word(5'($urandom_range(0, 31)), 16'($urandom));
        clear_frames(); take_snapshot(); add_pass(); add_pass();
        run_pass("pending", 500, 900, -1, blen);
        check("pending_busy_len", 48'(blen), 48'd6464);
        check_frames("pending");

        // Strobe in the very cycle the last GAP ends: extra pass via IDLE
        clear_frames(); take_snapshot(); add_pass(); add_pass();
        run_pass("gapedge", 3232, -1, -1, blen);
        check("gapedge_busy_len", 48'(blen), 48'd6465);
        check_frames("gapedge");

        // Writes while channel 7 is shifting: frame 7 old, frame 20 new
        clear_frames(); take_snapshot();
        snap[20] = 16'h0001;
        add_pass();
        run_pass("wrbusy", -1, -1, 710, blen);
        ram[7] = 16'hFFFF; ram[20] = 16'h0001;
        check("wrbusy_busy_len", 48'(blen), 48'd3232);
        check_frames("wrbusy");
        readback_all("wrbusy_read");

        // Reset in the middle of channel 3's SHIFT_HI
        clear_frames();
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        repeat (306) @(negedge clk);
        check("mid_sclk_hi", 48'(sclk), 48'd1);
        check("mid_nsync_chip0", 48'(nsync), 48'hE);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_nsync", 48'(nsync), 48'hF);
        check("mid_rst_sclk", 48'(sclk), 48'd0);
        check("mid_rst_busy", 48'(busy), 48'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        readback_all("mid_rst_read");
        repeat (30) @(negedge clk);
        check("post_rst_busy", 48'(busy), 48'd0);
        check("post_rst_nsync", 48'(nsync), 48'hF);
        check("post_rst_sclk", 48'(sclk), 48'd0);

        // Line-level timing properties seen over the whole run
        check("din_changed_while_sclk_high", 48'(din_glitch), 48'd0);
        check("nsync_changed_in_frame", 48'(bad_sync), 48'd0);
        check("sclk_outside_frame", 48'(stray), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
